code_sender: RTL and testbench

Transmitter side of the digit-entry interface used by the sequence lock. It latches a programmed code of `DIGITS` decimal digits, then emits each digit on `numero` with a one-cycle `insere` strobe, spaced by a fixed idle gap. It sits in front of the lock, or drives it in bench and self-test setups, replacing manual keypad entry.

---
 rtl/code_sender.sv | 222 ++++++++++++++++++++++
 tb/tb_code_sender.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_sender.sv
// code_sender: transmitter for the sequence-lock digit-entry interface.
// Latches a DIGITS-digit decimal code on an accepted start, then emits each
// digit on numero with a one-cycle insere strobe, separated by GAP idle cycles.
// Optional build macro: CODE_SENDER_ECHO_EN adds a registered active-low
// 7-segment echo of numero on the display port.
module code_sender #(
    parameter int DIGITS = 6,
    parameter int GAP    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [4*DIGITS-1:0] code_in,
    output logic [3:0]          numero,
    output logic                insere,
    output logic                busy,
    output logic                done,
    output logic                err
`ifdef CODE_SENDER_ECHO_EN
    ,
    output logic [6:0]          display
`endif
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int GAP_W = $clog2(GAP + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 1);
    localparam logic [3:0]       NO_DIGIT = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_FIN
    } state_t;

    state_t              state;
    logic [4*DIGITS-1:0] code_q;
    logic [IDX_W-1:0]    digit_idx;
    logic [GAP_W-1:0]    gap_cnt;

    logic                code_ok;
    logic                accept;
    logic                reject;
    logic                gap_done;
    logic                last_digit;
    logic [IDX_W-1:0]    idx_inc;
    logic [3:0]          next_digit;
    logic [3:0]          numero_nxt;

`ifdef CODE_SENDER_ECHO_EN
    // Active-low segments {a,b,c,d,e,f,g}; anything that is not a digit
    // shows only segment g lit-off pattern 1111110.
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111110;
        endcase
        return s;
    endfunction
`endif

    // Validate the incoming code: every digit must be a decimal value.
    always_comb begin
        code_ok = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (code_in[4*i +: 4] > 4'd9) begin
                code_ok = 1'b0;
            end
        end
    end

    // Start qualification and counter status decodes.
    always_comb begin
        accept     = (state == S_IDLE) && start && !abort && code_ok;
        reject     = (state == S_IDLE) && start && !abort && !code_ok;
        gap_done   = (gap_cnt == '0);
        last_digit = (digit_idx == LAST_IDX);
        idx_inc    = digit_idx + IDX_W'(1);
    end

    // Select the digit that follows the current one from the latched code.
    always_comb begin
        next_digit = NO_DIGIT;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_inc == IDX_W'(i)) begin
                next_digit = code_q[4*i +: 4];
            end
        end
    end

    // Next value of numero; shared by the numero and display registers so
    // both change on the same edge.
    always_comb begin
        numero_nxt = numero;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    numero_nxt = code_in[3:0];
                end
            end
            S_SEND: begin
                if (abort) begin
                    numero_nxt = NO_DIGIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    numero_nxt = NO_DIGIT;
                end else if (gap_done) begin
                    numero_nxt = last_digit ? NO_DIGIT : next_digit;
                end
            end
            S_FIN: begin
                numero_nxt = NO_DIGIT;
            end
            default: begin
                numero_nxt = NO_DIGIT;
            end
        endcase
    end

    // Registered digit output (and its optional segment echo).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            numero  <= NO_DIGIT;
`ifdef CODE_SENDER_ECHO_EN
            display <= 7'b1111110;
`endif
        end else begin
            numero  <= numero_nxt;
`ifdef CODE_SENDER_ECHO_EN
            display <= seg_of(numero_nxt);
`endif
        end
    end

    // Transfer FSM with registered strobe/status outputs and counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            code_q    <= '0;
            digit_idx <= '0;
            gap_cnt   <= '0;
            insere    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            insere <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state     <= S_SEND;
                        code_q    <= code_in;
                        digit_idx <= '0;
                        insere    <= 1'b1;
                        busy      <= 1'b1;
                    end else if (reject) begin
                        err <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (abort) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        digit_idx <= '0;
                        gap_cnt   <= '0;
                    end else begin
                        state   <= S_WAIT;
                        gap_cnt <= GAP_LOAD;
                    end
                end
                S_WAIT: begin
                    if (abort) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        digit_idx <= '0;
                        gap_cnt   <= '0;
                    end else if (gap_done) begin
                        if (last_digit) begin
                            state <= S_FIN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state     <= S_SEND;
                            digit_idx <= idx_inc;
                            insere    <= 1'b1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                S_FIN: begin
                    state     <= S_IDLE;
                    digit_idx <= '0;
                    gap_cnt   <= '0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_code_sender.sv
// Bench for code_sender: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a timing-formula model.
module tb_code_sender;

    localparam int DIGITS   = 6;
    localparam int GAP      = 4;
    localparam int PERIOD   = GAP + 1;
    localparam int LAST_POS = DIGITS * PERIOD + 1;

    logic                clk     = 1'b0;
    logic                reset   = 1'b1;
    logic                start   = 1'b0;
    logic                abort   = 1'b0;
    logic [4*DIGITS-1:0] code_in = '0;
    logic [3:0]          numero;
    logic                insere;
    logic                busy;
    logic                done;
    logic                err;
`ifdef CODE_SENDER_ECHO_EN
    logic [6:0]          display;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model: pos is the cycle offset since the accepted start (0 = idle).
    int pos = 0;
    int mdig[DIGITS];
    bit exp_err = 1'b0;

    int st_off[$];
    int st_dig[$];
    int done_off;
    int n_st;
    int n_dn;

    code_sender #(.DIGITS(DIGITS), .GAP(GAP)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .abort   (abort),
        .code_in (code_in),
        .numero  (numero),
        .insere  (insere),
        .busy    (busy),
        .done    (done),
        .err     (err)
`ifdef CODE_SENDER_ECHO_EN
        ,
        .display (display)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic bit code_valid(input logic [4*DIGITS-1:0] c);
        bit ok = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (c[4*d +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic int seg_of(input int n);
        int tab[10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
        if (n >= 0 && n <= 9) return tab[n];
        return 7'b1111110;
    endfunction

    function automatic int m_numero();
        if (pos >= 1 && pos < LAST_POS) return mdig[(pos - 1) / PERIOD];
        return 15;
    endfunction

    function automatic int m_insere();
        return (pos >= 1 && pos < LAST_POS && ((pos - 1) % PERIOD) == 0) ? 1 : 0;
    endfunction

    function automatic int m_busy();
        return (pos >= 1 && pos < LAST_POS) ? 1 : 0;
    endfunction

    function automatic int m_done();
        return (pos == LAST_POS) ? 1 : 0;
    endfunction

    // Reference model update on each clock edge or asynchronous reset.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos     = 0;
            exp_err = 1'b0;
        end else begin
            exp_err = 1'b0;
            if (pos != 0) begin
                if (abort || pos == LAST_POS) pos = 0;
                else pos = pos + 1;
            end else if (start && !abort) begin
                if (code_valid(code_in)) begin
                    for (int d = 0; d < DIGITS; d++) mdig[d] = int'(code_in[4*d +: 4]);
                    pos = 1;
                end else begin
                    exp_err = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("numero", numero, m_numero());
            chk("insere", insere, m_insere());
            chk("busy",   busy,   m_busy());
            chk("done",   done,   m_done());
            chk("err",    err,    exp_err ? 1 : 0);
`ifdef CODE_SENDER_ECHO_EN
            chk("display", display, seg_of(m_numero()));
`endif
        end
    end

    initial begin
        int exp_off[6] = '{1, 6, 11, 16, 21, 26};
        int exp_d1[6]  = '{5, 3, 7, 9, 5, 9};
        int exp_d4[6]  = '{2, 9, 7, 5, 3, 1};
        int nib;

        #1 reset = 1'b0;
        #3;
        chk("rst_numero", numero, 15);
        chk("rst_insere", insere, 0);
        chk("rst_busy",   busy,   0);
        chk("rst_done",   done,   0);
        chk("rst_err",    err,    0);
`ifdef CODE_SENDER_ECHO_EN
        chk("rst_display", display, 7'b1111110);
`endif
        chk_en = 1'b1;
        step(3);
        reset = 1'b1;
        step(2);

        // Nominal transfer of 959735 (sent LSB digit first).
        code_in = 24'h959735;
        start = 1'b1;
        step(1);
        start = 1'b0;
        st_off.delete(); st_dig.delete(); done_off = -1;
        for (int o = 1; o <= 32; o++) begin
            if (insere) begin st_off.push_back(o); st_dig.push_back(int'(numero)); end
            if (done) done_off = o;
`ifdef CODE_SENDER_ECHO_EN
            if (insere && numero == 4'd5) chk("t1_disp5", display, 7'b0100100);
            if (insere && numero == 4'd7) chk("t1_disp7", display, 7'b0001111);
            if (o == 32) chk("t1_disp_idle", display, 7'b1111110);
`endif
            if (o == 31) chk("t1_busy_at_done", busy, 0);
            if (o == 32) chk("t1_busy_after", busy, 0);
            step(1);
        end
        chk("t1_strobes", st_off.size(), 6);
        for (int k = 0; k < 6 && k < st_off.size(); k++) begin
            chk("t1_strobe_cycle", st_off[k], exp_off[k]);
            chk("t1_digit", st_dig[k], exp_d1[k]);
        end
        chk("t1_done_cycle", done_off, 31);

        // Invalid digit rejected with an err pulse.
        code_in = 24'h12A456;
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("t2_err", err, 1);
        chk("t2_insere", insere, 0);
        chk("t2_busy", busy, 0);
        step(1);
        chk("t2_err_clear", err, 0);
        chk("t2_busy_after", busy, 0);
        step(2);

        // Abort in the third digit's gap.
        code_in = 24'h012345;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(11);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("t3_numero", numero, 15);
        chk("t3_busy", busy, 0);
        chk("t3_insere", insere, 0);
        n_st = 0; n_dn = 0;
        for (int o = 0; o < 30; o++) begin
            if (insere) n_st++;
            if (done) n_dn++;
            step(1);
        end
        chk("t3_no_strobes", n_st, 0);
        chk("t3_no_done", n_dn, 0);

        // Start while busy is ignored.
        code_in = 24'h135792;
        start = 1'b1;
        step(1);
        start = 1'b0;
        st_off.delete(); st_dig.delete(); done_off = -1;
        for (int o = 1; o <= 32; o++) begin
            if (o == 8) begin code_in = 24'h864200; start = 1'b1; end
            if (o == 9) start = 1'b0;
            if (insere) begin st_off.push_back(o); st_dig.push_back(int'(numero)); end
            if (done) done_off = o;
            step(1);
        end
        chk("t4_strobes", st_off.size(), 6);
        for (int k = 0; k < 6 && k < st_off.size(); k++) begin
            chk("t4_strobe_cycle", st_off[k], exp_off[k]);
            chk("t4_digit", st_dig[k], exp_d4[k]);
        end
        chk("t4_done_cycle", done_off, 31);

        // Reset mid-transfer, then a fresh transfer from digit 0.
        code_in = 24'h246802;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(16);
        reset = 1'b0;
        #1;
        chk("t5_numero", numero, 15);
        chk("t5_insere", insere, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_err", err, 0);
        step(2);
        reset = 1'b1;
        step(1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("t5_restart_insere", insere, 1);
        chk("t5_restart_digit0", numero, 2);
        chk("t5_restart_busy", busy, 1);
        step(32);

        // Randomized traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            start = ($urandom_range(0, 5) == 0);
            abort = ($urandom_range(0, 79) == 0);
            for (int d = 0; d < DIGITS; d++) begin
                if ($urandom_range(0, 11) == 0) nib = int'($urandom_range(10, 15));
                else nib = int'($urandom_range(0, 9));
                code_in[4*d +: 4] = 4'(nib);
            end
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b0;
                step(1);
                reset = 1'b1;
            end else begin
                step(1);
            end
        end
        start = 1'b0;
        abort = 1'b0;
        step(40);

        chk_en = 1'b0;
        step(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
